// File: rtl/rv_muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module rv_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic              r_busy;
  logic              r_done;

  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg_start;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_shift;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dsel, w_dres, w_fix_res;

  // Operand conditioning at launch: magnitudes plus the sign the final result must carry.
  always_comb begin
    w_a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_a_neg     = w_a_signed & op_a[XLEN-1];
    w_b_neg     = w_b_signed & op_b[XLEN-1];
    w_a_mag     = w_a_neg ? -op_a : op_a;
    w_b_mag     = w_b_neg ? -op_b : op_b;
    w_div0      = funct3[2] && (op_b == '0);
    w_ovf       = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    w_fast      = w_div0 || w_ovf;
    w_fast_res  = '0;
    if (w_div0)
      w_fast_res = funct3[1] ? op_a : '1;
    else if (w_ovf)
      w_fast_res = funct3[1] ? '0 : op_a;
    case (funct3)
      3'b001, 3'b100: w_neg_start = w_a_neg ^ w_b_neg;
      3'b010, 3'b110: w_neg_start = w_a_neg;
      default:        w_neg_start = 1'b0;
    endcase
  end

  // Multiply keeps the partial product in the upper half and the multiplier in the lower half;
  // divide reuses the same register as {remainder, dividend/quotient}.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_sum, r_acc[XLEN-1:1]};
    w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge       = (w_shift >= {1'b0, r_b});
    w_diff     = w_shift[XLEN-1:0] - r_b;
    w_div_next = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                      : {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_dsel = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    w_dres = r_neg ? -w_dsel : w_dsel;
    if (r_f3[2])
      w_fix_res = w_dres;
    else if (r_f3[1:0] == 2'b00)
      w_fix_res = w_prod[XLEN-1:0];
    else
      w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end else begin
              r_f3    <= funct3;
              r_neg   <= w_neg_start;
              r_b     <= w_b_mag;
              r_acc   <= {{XLEN{1'b0}}, w_a_mag};
              r_cnt   <= CW'(XLEN - 1);
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_f3[2] ? w_div_next : w_mul_next;
          if (r_cnt == '0)
            r_state <= S_FIX;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed + small randomized bench for rv_muldiv_unit (XLEN=32) with a result scoreboard.
module tb_rv_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int LAT = XLEN + 1;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] sb_q[$];

  rv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a launch and passes the sampling edge; start stays high if hold=1.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit hold);
    sb_q.push_back(exp);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    int busy_cnt;
    logic [31:0] exp;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busycyc"}, busy_cnt, exp_lat);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_result"}, result, exp);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb, ex;
    logic [63:0] p;
    longint sp;
    logic signed [31:0] sa, sb;

    reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    reset = 1'b0;
    tick();

    vecs.push_back('{"mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT});
    vecs.push_back('{"mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT});
    vecs.push_back('{"mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT});
    vecs.push_back('{"mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT});
    vecs.push_back('{"div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT});
    vecs.push_back('{"rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT});
    vecs.push_back('{"divu",    3'b101, 32'd100,      32'd7,        32'd14,       LAT});
    vecs.push_back('{"remu",    3'b111, 32'd100,      32'd7,        32'd2,        LAT});
    vecs.push_back('{"divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{"rem_z",   3'b110, 32'd5,        32'd0,        32'd5,        0});
    vecs.push_back('{"div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    vecs.push_back('{"rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0});
    vecs.push_back('{"divu_ovfpat", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0,    LAT});

    foreach (vecs[i]) begin
      launch(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
      wait_done(vecs[i].tag, vecs[i].lat);
      tick();
      chk({vecs[i].tag, "_done_pulse"}, done, 1'b0);
      chk({vecs[i].tag, "_hold"}, result, vecs[i].exp);
    end

    // Independent arithmetic model for random operands.
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom_range(32'h7FFFFFFF, 1);
      sa = ra; sb = rb;
      p = {32'b0, ra} * {32'b0, rb};
      ex = p[63:32];
      launch(3'b011, ra, rb, ex, 1'b0); wait_done("rnd_mulhu", LAT); tick();
      sp = longint'(sa) * longint'(sb);
      p = sp;
      ex = p[63:32];
      launch(3'b001, ra, rb, ex, 1'b0); wait_done("rnd_mulh", LAT); tick();
      ex = sa / sb;
      launch(3'b100, ra, rb, ex, 1'b0); wait_done("rnd_div", LAT); tick();
      ex = sa % sb;
      launch(3'b110, ra, rb, ex, 1'b0); wait_done("rnd_rem", LAT); tick();
    end

    // start during CALC with new operands must be ignored.
    launch(3'b101, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (9) tick();
    funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore", LAT - 10);
    tick();

    // Synchronous reset mid-CALC.
    launch(3'b000, 32'd12, 32'd12, 32'd144, 1'b0);
    void'(sb_q.pop_back());
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 32'h0);
    repeat (LAT + 2) begin
      tick();
      chk("midrst_idle_done", done, 1'b0);
    end

    // start held through DONE: second op launches on the DONE edge.
    launch(3'b000, 32'd3, 32'd5, 32'd15, 1'b1);
    funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5;
    sb_q.push_back(32'd10);
    wait_done("b2b_first", LAT);
    tick();
    start = 1'b0;
    chk("b2b_single_pulse", done, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    wait_done("b2b_second", LAT);
    tick();
    chk("b2b_end", done, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
